// File: rtl/i2s_tdm_clkgen.sv
// I2S / TDM master clock generator: SCK and WS for 2..MAX_CHNL-slot frames in I2S, LJ, DSP-A and DSP-B formats.
// Edge strobes and bit/slot position let the shifters run on clk_i without sampling sck_o.
module i2s_tdm_clkgen #(
  parameter int DIV_WIDTH = 16,
  parameter int MAX_CHNL  = 8,
  parameter int SLOT_W    = $clog2(MAX_CHNL)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 pol_i,
  input  logic                 wspol_i,
  input  logic [1:0]           fmt_i,
  input  logic [1:0]           chl_i,
  input  logic [SLOT_W-1:0]    chn_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 sck_lead_o,
  output logic                 sck_trail_o,
  output logic [4:0]           bit_idx_o,
  output logic [SLOT_W-1:0]    slot_idx_o,
  output logic                 frame_start_o
);

  localparam logic [1:0] FMT_I2S  = 2'b00;
  localparam logic [1:0] FMT_LJ   = 2'b01;
  localparam logic [1:0] FMT_DSPA = 2'b10;
  localparam logic [1:0] FMT_DSPB = 2'b11;

  // Highest bit index of a slot for a given slot-width code.
  function automatic logic [4:0] width_m1(input logic [1:0] chl);
    logic [4:0] r;
    case (chl)
      2'b00:   r = 5'd7;
      2'b01:   r = 5'd15;
      2'b10:   r = 5'd23;
      default: r = 5'd31;
    endcase
    return r;
  endfunction

  // Upper half of the frame drives the opposite WS level; a single-slot frame has no upper half.
  function automatic logic grp(input logic [SLOT_W-1:0] chn, input logic [SLOT_W-1:0] slot);
    logic [SLOT_W:0] half;
    half = ({1'b0, chn} + {{SLOT_W{1'b0}}, 1'b1}) >> 1;
    return (chn != {SLOT_W{1'b0}}) && ({1'b0, slot} >= half);
  endfunction

  // WS level while the bit at (slot, bit_v) is on the wire.
  function automatic logic ws_calc(
    input logic [1:0]        fmt,
    input logic [SLOT_W-1:0] chn,
    input logic              wspol,
    input logic [SLOT_W-1:0] slot,
    input logic [4:0]        bit_v,
    input logic [4:0]        wm1
  );
    logic [SLOT_W-1:0] nslot;
    logic              r;
    nslot = (bit_v != 5'd0) ? slot :
            (slot == chn)   ? {SLOT_W{1'b0}} : slot + SLOT_W'(1);
    case (fmt)
      FMT_I2S:  r = wspol ^ grp(chn, nslot);
      FMT_LJ:   r = wspol ^ grp(chn, slot);
      FMT_DSPA: r = wspol ^ ((slot == chn) && (bit_v == 5'd0));
      FMT_DSPB: r = wspol ^ ((slot == {SLOT_W{1'b0}}) && (bit_v == wm1));
      default:  r = wspol;
    endcase
    return r;
  endfunction

  logic                 rst_meta_r, rst_sync_r, armed_r;
  logic [1:0]           fmt_r, fmt_s, chl_r, chl_s;
  logic [SLOT_W-1:0]    chn_r, chn_s;
  logic [DIV_WIDTH-1:0] div_r, div_s, cnt_r, cnt_s;
  logic                 sck_r, sck_s, ws_r, ws_s;
  logic                 lead_r, lead_s, trail_r, trail_s, fs_r, fs_s;
  logic [4:0]           bit_r, bit_s, wm1_s;
  logic [SLOT_W-1:0]    slot_r, slot_s;

  // Reset synchronizer: asserts immediately, releases on clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Next-state: idle reload (also on the first cycle out of reset), divider, edge strobes, position and WS.
  always_comb begin
    fmt_s   = fmt_r;
    chl_s   = chl_r;
    chn_s   = chn_r;
    div_s   = div_r;
    cnt_s   = cnt_r;
    sck_s   = sck_r;
    ws_s    = ws_r;
    bit_s   = bit_r;
    slot_s  = slot_r;
    lead_s  = 1'b0;
    trail_s = 1'b0;
    fs_s    = 1'b0;
    wm1_s   = width_m1(chl_r);
    if (!en_i || !armed_r) begin
      fmt_s  = fmt_i;
      chl_s  = chl_i;
      chn_s  = chn_i;
      div_s  = div_i;
      wm1_s  = width_m1(chl_i);
      cnt_s  = div_i;
      sck_s  = pol_i;
      bit_s  = wm1_s;
      slot_s = {SLOT_W{1'b0}};
      ws_s   = ws_calc(fmt_i, chn_i, wspol_i, {SLOT_W{1'b0}}, wm1_s, wm1_s);
    end else if (cnt_r == {DIV_WIDTH{1'b0}}) begin
      cnt_s = div_r;
      sck_s = ~sck_r;
      if (sck_r == pol_i) begin
        lead_s = 1'b1;
        fs_s   = (slot_r == {SLOT_W{1'b0}}) && (bit_r == wm1_s);
      end else begin
        trail_s = 1'b1;
        if (bit_r == 5'd0) begin
          bit_s = wm1_s;
          if (slot_r == chn_r) begin
            slot_s = {SLOT_W{1'b0}};
          end else begin
            slot_s = slot_r + SLOT_W'(1);
          end
        end else begin
          bit_s = bit_r - 5'd1;
        end
        ws_s = ws_calc(fmt_r, chn_r, wspol_i, slot_s, bit_s, wm1_s);
      end
    end else begin
      cnt_s = cnt_r - DIV_WIDTH'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      armed_r <= 1'b0;
      fmt_r   <= 2'b00;
      chl_r   <= 2'b00;
      chn_r   <= {SLOT_W{1'b0}};
      div_r   <= {DIV_WIDTH{1'b0}};
      cnt_r   <= {DIV_WIDTH{1'b0}};
      sck_r   <= 1'b0;
      ws_r    <= 1'b0;
      lead_r  <= 1'b0;
      trail_r <= 1'b0;
      fs_r    <= 1'b0;
      bit_r   <= 5'd0;
      slot_r  <= {SLOT_W{1'b0}};
    end else begin
      armed_r <= 1'b1;
      fmt_r   <= fmt_s;
      chl_r   <= chl_s;
      chn_r   <= chn_s;
      div_r   <= div_s;
      cnt_r   <= cnt_s;
      sck_r   <= sck_s;
      ws_r    <= ws_s;
      lead_r  <= lead_s;
      trail_r <= trail_s;
      fs_r    <= fs_s;
      bit_r   <= bit_s;
      slot_r  <= slot_s;
    end
  end

  assign sck_o         = sck_r;
  assign ws_o          = ws_r;
  assign sck_lead_o    = lead_r;
  assign sck_trail_o   = trail_r;
  assign bit_idx_o     = bit_r;
  assign slot_idx_o    = slot_r;
  assign frame_start_o = fs_r;

endmodule
